f3_move_ctrl: RTL and testbench

Write-side controller for the f3 tile-offset RAM. It accepts player and system move commands through a valid/ready handshake and drives the RAM write port as single-cycle write pulses. It keeps a move history for undo, generates LFSR-driven scrambles, and auto-solves by replaying inverse moves. It sits between the input decoder and f3_ram, and reads back the RAM's all-zero flag to report a solved board.

---
 rtl/f3_pkg.sv | 48 ++++
 rtl/f3_move_hist.sv | 55 +++++
 rtl/f3_move_ctrl.sv | 178 +++++++++++++++++
 tb/tb_f3_move_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f3_pkg.sv
// Shared types for the f3 move controller: command encodings, FSM states,
// the move record and small helpers for inverse moves and the scramble LFSR.
package f3_pkg;

  typedef enum logic [1:0] {
    OP_MOVE     = 2'd0,
    OP_UNDO     = 2'd1,
    OP_SCRAMBLE = 2'd2,
    OP_SOLVE    = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_CHECK,
    ST_RSTP
  } state_e;

  typedef struct packed {
    logic [3:0] pos;
    logic       horizontal;
    logic       increase;
  } move_t;

  // Undoing a move shifts the same row/column the other way.
  function automatic move_t move_inverse(input move_t m);
    move_t r;
    r          = m;
    r.increase = ~m.increase;
    return r;
  endfunction

  // 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Scramble move fields taken straight from the low LFSR bits.
  function automatic move_t lfsr_move(input logic [15:0] s);
    move_t m;
    m.pos        = s[3:0];
    m.horizontal = s[4];
    m.increase   = s[5];
    return m;
  endfunction

endpackage

// File: rtl/f3_move_hist.sv
// Circular LIFO of moves for undo/solve. Pushing onto a full stack drops the
// oldest entry; the count saturates at DEPTH.
module f3_move_hist
  import f3_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  move_t                  push_mv,
  input  logic                   pop,
  output move_t                  top_mv,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  move_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic          full;

  // When full, wr_ptr points at the oldest slot, so a push overwrites it.
  assign full    = (count == CNT_MAX);
  assign top_ptr = wr_ptr - PTR_ONE;
  assign top_mv  = mem[top_ptr];

  // Stack pointer and occupancy; clear empties the stack without moving the pointer.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (pop && (count != '0)) begin
      wr_ptr <= wr_ptr - PTR_ONE;
      count  <= count - CNT_ONE;
    end
  end

  // Move storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge sysclk) begin
    if (push && !clr) mem[wr_ptr] <= push_mv;
  end

endmodule

// File: rtl/f3_move_ctrl.sv
// Write-side controller for the f3 tile-offset RAM: accepts move/undo/
// scramble/solve commands and paces single-cycle RAM write pulses.
module f3_move_ctrl
  import f3_pkg::*;
#(
  parameter int          HIST_DEPTH     = 64,
  parameter int          STEP_CYCLES    = 4,
  parameter int          SCRAMBLE_MOVES = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [3:0]                  cmd_pos,
  input  logic                        cmd_horizontal,
  input  logic                        cmd_increase,
  input  logic                        clear,
  output logic                        ram_write,
  output logic [3:0]                  ram_write_pos,
  output logic                        ram_write_horizontal,
  output logic                        ram_write_increase,
  output logic                        ram_reset,
  input  logic                        ram_offset_all_zero,
  output logic                        busy,
  output logic                        solved,
  output logic [$clog2(HIST_DEPTH):0] hist_count
);

  localparam int GW = $clog2(STEP_CYCLES + 1);
  localparam int RW = 8;
  localparam logic [GW-1:0] GAP_LOAD = GW'(STEP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [RW-1:0] REM_LOAD = RW'(SCRAMBLE_MOVES);
  localparam logic [RW-1:0] REM_ONE  = RW'(1);

  state_e        state, state_d;
  cmd_op_e       op_q, op_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          solved_q, solved_d;
  logic [15:0]   lfsr_q;
  move_t         cur_q, cur_d;
  logic          load_cur;
  logic          push, pop, hclr;
  move_t         top_mv, issue_mv;

  f3_move_hist #(.DEPTH(HIST_DEPTH)) u_hist (
    .sysclk  (sysclk),
    .reset   (reset),
    .clr     (hclr),
    .push    (push),
    .push_mv (issue_mv),
    .pop     (pop),
    .top_mv  (top_mv),
    .count   (hist_count)
  );

  // Scramble writes take the live LFSR value; everything else replays cur_q.
  assign issue_mv = (op_q == OP_SCRAMBLE) ? lfsr_move(lfsr_q) : cur_q;

  assign ram_write            = (state == ST_ISSUE);
  assign ram_write_pos        = ram_write ? issue_mv.pos : 4'd0;
  assign ram_write_horizontal = ram_write & issue_mv.horizontal;
  assign ram_write_increase   = ram_write & issue_mv.increase;
  assign ram_reset            = (state == ST_RSTP);
  assign busy                 = (state != ST_IDLE);
  assign cmd_ready            = (state == ST_IDLE) && !clear;
  assign solved               = solved_q;

  // Next-state and sequencing decisions; clear overrides whatever is in flight.
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    gap_d    = gap_q;
    rem_d    = rem_q;
    solved_d = solved_q;
    cur_d    = move_inverse(top_mv);
    load_cur = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    hclr     = 1'b0;
    if (clear) begin
      state_d = ST_RSTP;
      op_d    = OP_MOVE;
      hclr    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_d = cmd_op_e'(cmd_op);
            case (cmd_op_e'(cmd_op))
              OP_MOVE: begin
                cur_d    = '{pos: cmd_pos, horizontal: cmd_horizontal, increase: cmd_increase};
                load_cur = 1'b1;
                state_d  = ST_ISSUE;
              end
              OP_SCRAMBLE: begin
                rem_d   = REM_LOAD;
                state_d = ST_ISSUE;
              end
              default: begin
                // UNDO and SOLVE both start by replaying the newest entry.
                if (hist_count != '0) begin
                  pop      = 1'b1;
                  load_cur = 1'b1;
                  state_d  = ST_ISSUE;
                end else begin
                  state_d = ST_CHECK;
                end
              end
            endcase
          end
        end
        ST_ISSUE: begin
          push    = (op_q == OP_MOVE) || (op_q == OP_SCRAMBLE);
          if (op_q == OP_SCRAMBLE) rem_d = rem_q - REM_ONE;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
        ST_GAP: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GAP_ONE;
          end else if ((op_q == OP_SCRAMBLE) && (rem_q != '0)) begin
            state_d = ST_ISSUE;
          end else if ((op_q == OP_SOLVE) && (hist_count != '0)) begin
            pop      = 1'b1;
            load_cur = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          solved_d = ram_offset_all_zero;
          // A solve that still leaves offsets lost history to overwrite; wipe the board.
          if ((op_q == OP_SOLVE) && !ram_offset_all_zero) begin
            op_d    = OP_MOVE;
            state_d = ST_RSTP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RSTP: begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers and the free-running LFSR.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MOVE;
      gap_q    <= '0;
      rem_q    <= '0;
      solved_q <= 1'b1;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state    <= state_d;
      op_q     <= op_d;
      gap_q    <= gap_d;
      rem_q    <= rem_d;
      solved_q <= solved_d;
      lfsr_q   <= lfsr_step(lfsr_q);
    end
  end

  // Latched move for the next write pulse.
  always_ff @(posedge sysclk) begin
    if (load_cur) cur_q <= cur_d;
  end

endmodule

// File: tb/tb_f3_move_ctrl.sv
// Directed bench for f3_move_ctrl with a behavioural tile-offset RAM model.
module tb_f3_move_ctrl;
  import f3_pkg::*;

  localparam int STEP = 4;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic       reset;
  logic       cmd_valid, clear, sel;
  logic [1:0] cmd_op;
  logic [3:0] cmd_pos;
  logic       cmd_h, cmd_inc;

  logic [1:0] cv, cl, cr, rw, rh, ri, rr, bz, sv, az;
  logic [3:0] rpos0, rpos1;
  logic [6:0] hc0;
  logic [2:0] hc1;

  assign cv[0] = cmd_valid & ~sel;
  assign cv[1] = cmd_valid & sel;
  assign cl[0] = clear & ~sel;
  assign cl[1] = clear & sel;

  f3_move_ctrl #(.HIST_DEPTH(64), .STEP_CYCLES(STEP), .SCRAMBLE_MOVES(32), .LFSR_SEED(16'hACE1)) u_dut (
    .sysclk(sysclk), .reset(reset), .cmd_valid(cv[0]), .cmd_ready(cr[0]), .cmd_op(cmd_op),
    .cmd_pos(cmd_pos), .cmd_horizontal(cmd_h), .cmd_increase(cmd_inc), .clear(cl[0]),
    .ram_write(rw[0]), .ram_write_pos(rpos0), .ram_write_horizontal(rh[0]),
    .ram_write_increase(ri[0]), .ram_reset(rr[0]), .ram_offset_all_zero(az[0]),
    .busy(bz[0]), .solved(sv[0]), .hist_count(hc0));

  f3_move_ctrl #(.HIST_DEPTH(4), .STEP_CYCLES(STEP), .SCRAMBLE_MOVES(32), .LFSR_SEED(16'hACE1)) u_dut4 (
    .sysclk(sysclk), .reset(reset), .cmd_valid(cv[1]), .cmd_ready(cr[1]), .cmd_op(cmd_op),
    .cmd_pos(cmd_pos), .cmd_horizontal(cmd_h), .cmd_increase(cmd_inc), .clear(cl[1]),
    .ram_write(rw[1]), .ram_write_pos(rpos1), .ram_write_horizontal(rh[1]),
    .ram_write_increase(ri[1]), .ram_reset(rr[1]), .ram_offset_all_zero(az[1]),
    .busy(bz[1]), .solved(sv[1]), .hist_count(hc1));

  // RAM model: per-line offsets mod 16, all-zero flag refreshed on non-write cycles.
  bit [3:0] off [2][2][16];
  bit       nz_q [2];

  function automatic bit any_nz(input int d);
    for (int h = 0; h < 2; h++)
      for (int p = 0; p < 16; p++)
        if (off[d][h][p] != 4'd0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge sysclk) begin
    for (int d = 0; d < 2; d++) begin
      if (rw[d]) begin
        if (ri[d]) off[d][rh[d]][(d == 0) ? rpos0 : rpos1] <= off[d][rh[d]][(d == 0) ? rpos0 : rpos1] + 4'd1;
        else       off[d][rh[d]][(d == 0) ? rpos0 : rpos1] <= off[d][rh[d]][(d == 0) ? rpos0 : rpos1] - 4'd1;
      end else begin
        nz_q[d] <= any_nz(d);
        if (rr[d])
          for (int h = 0; h < 2; h++)
            for (int p = 0; p < 16; p++)
              off[d][h][p] <= 4'd0;
      end
    end
  end

  assign az[0] = ~nz_q[0];
  assign az[1] = ~nz_q[1];

  // Reference LFSR: taps 16/14/13/11, steps every cycle out of reset.
  logic [15:0] lfsr_ref;
  always @(posedge sysclk or posedge reset) begin
    if (reset) lfsr_ref <= 16'hACE1;
    else       lfsr_ref <= {lfsr_ref[14:0], lfsr_ref[15] ^ lfsr_ref[13] ^ lfsr_ref[12] ^ lfsr_ref[10]};
  end

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Monitor: logs writes, reset pulses and busy/ready activity on the falling edge.
  int wr_cnt[2], rst_cnt[2], busy_cnt[2], rlow_cnt[2], busy_last[2], rst_last[2];
  bit overlap;
  logic [5:0] wv0[$], we0[$], wv1[$];
  int         wc0[$];

  always @(negedge sysclk) begin
    for (int d = 0; d < 2; d++) begin
      if (rw[d]) wr_cnt[d] <= wr_cnt[d] + 1;
      if (rr[d]) begin
        rst_cnt[d]  <= rst_cnt[d] + 1;
        rst_last[d] <= cyc;
      end
      if (rw[d] & rr[d]) overlap <= 1'b1;
      if (bz[d]) begin
        busy_cnt[d]  <= busy_cnt[d] + 1;
        busy_last[d] <= cyc;
      end
      if (!cr[d]) rlow_cnt[d] <= rlow_cnt[d] + 1;
    end
    if (rw[0]) begin
      wv0.push_back({rpos0, rh[0], ri[0]});
      wc0.push_back(cyc);
      we0.push_back({lfsr_ref[3:0], lfsr_ref[4], lfsr_ref[5]});
    end
    if (rw[1]) wv1.push_back({rpos1, rh[1], ri[1]});
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] pos, input logic h,
                      input logic inc, output int t);
    t = -1;
    @(posedge sysclk); #1;
    cmd_op = op; cmd_pos = pos; cmd_h = h; cmd_inc = inc; cmd_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge sysclk);
      if (sel ? cr[1] : cr[0]) begin
        t = cyc;
        break;
      end
    end
    @(posedge sysclk); #1;
    cmd_valid = 1'b0;
    if (t < 0) chk("handshake_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int maxc);
    bit to;
    to = 1'b1;
    @(posedge sysclk);
    for (int n = 0; n < maxc; n++) begin
      @(negedge sysclk);
      if (!(sel ? bz[1] : bz[0])) begin
        to = 1'b0;
        break;
      end
    end
    #1;
    if (to) chk("idle_timeout", 1, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, b, b2, sb, bb, rl, rb, w, bad, sbad;
    sel = 1'b0; cmd_valid = 1'b0; clear = 1'b0;
    cmd_op = 2'd0; cmd_pos = 4'd0; cmd_h = 1'b0; cmd_inc = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_ram_write", rw[0], 0);
    chk("rst_ram_reset", rr[0], 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_cmd_ready", cr[0], 1);
    chk("rst_solved", sv[0], 1);
    chk("rst_hist_count", hc0, 0);
    @(negedge sysclk); reset = 1'b0;
    repeat (2) @(posedge sysclk);

    // MOVE 5/1/1
    b = wr_cnt[0]; bb = busy_cnt[0]; rl = rlow_cnt[0];
    send(2'd0, 4'd5, 1'b1, 1'b1, t);
    wait_idle(40);
    chk("move_nwrites", wr_cnt[0] - b, 1);
    chk("move_write_cycle", wc0[b], t + 1);
    chk("move_fields", wv0[b], 6'h17);
    chk("move_hist_count", hc0, 1);
    chk("move_busy_cycles", busy_cnt[0] - bb, STEP + 2);
    chk("move_ready_low_cycles", rlow_cnt[0] - rl, STEP + 2);
    chk("move_busy_last", busy_last[0], t + 2 + STEP);
    chk("move_solved", sv[0], 0);

    // UNDO
    b = wr_cnt[0];
    send(2'd1, 4'd0, 1'b0, 1'b0, t);
    wait_idle(40);
    chk("undo_nwrites", wr_cnt[0] - b, 1);
    chk("undo_fields", wv0[b], 6'h16);
    chk("undo_hist_count", hc0, 0);
    chk("undo_solved", sv[0], 1);

    // SCRAMBLE
    b = wr_cnt[0]; sb = b; rb = rst_cnt[0];
    send(2'd2, 4'd0, 1'b0, 1'b0, t);
    wait_idle(400);
    chk("scr_nwrites", wr_cnt[0] - b, 32);
    chk("scr_first_cycle", wc0[b], t + 1);
    bad = 0; sbad = 0;
    for (int i = 0; i < 32; i++) begin
      if (wv0[b + i] !== we0[b + i]) bad++;
      if (i > 0 && (wc0[b + i] - wc0[b + i - 1]) != STEP + 1) sbad++;
    end
    chk("scr_field_errors", bad, 0);
    chk("scr_spacing_errors", sbad, 0);
    chk("scr_hist_count", hc0, 32);

    // SOLVE after scramble
    b2 = wr_cnt[0];
    send(2'd3, 4'd0, 1'b0, 1'b0, t);
    wait_idle(400);
    chk("solve_nwrites", wr_cnt[0] - b2, 32);
    bad = 0; sbad = 0;
    for (int i = 0; i < 32; i++) begin
      if (wv0[b2 + i] !== (we0[sb + 31 - i] ^ 6'h01)) bad++;
      if (i > 0 && (wc0[b2 + i] - wc0[b2 + i - 1]) != STEP + 1) sbad++;
    end
    chk("solve_field_errors", bad, 0);
    chk("solve_spacing_errors", sbad, 0);
    chk("solve_no_ram_reset", rst_cnt[0] - rb, 0);
    chk("solve_hist_count", hc0, 0);
    chk("solve_solved", sv[0], 1);

    // clear during the 10th scramble write
    b = wr_cnt[0]; rb = rst_cnt[0];
    send(2'd2, 4'd0, 1'b0, 1'b0, t);
    w = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge sysclk); #1;
      if (wr_cnt[0] - b >= 10) begin
        w = wc0[b + 9];
        break;
      end
    end
    clear = 1'b1;
    @(posedge sysclk); #1;
    clear = 1'b0;
    wait_idle(50);
    chk("clr_nwrites", wr_cnt[0] - b, 10);
    chk("clr_ram_reset_pulses", rst_cnt[0] - rb, 1);
    chk("clr_ram_reset_cycle", rst_last[0], w + 1);
    chk("clr_hist_count", hc0, 0);
    chk("clr_solved", sv[0], 1);
    chk("clr_cmd_ready", cr[0], 1);

    // clear and cmd_valid together in IDLE
    b = wr_cnt[0]; rb = rst_cnt[0];
    @(posedge sysclk); #1;
    clear = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_pos = 4'd3;
    @(negedge sysclk);
    chk("clr_valid_ready_low", cr[0], 0);
    @(posedge sysclk); #1;
    clear = 1'b0; cmd_valid = 1'b0;
    wait_idle(50);
    chk("clr_valid_nwrites", wr_cnt[0] - b, 0);
    chk("clr_valid_reset_pulses", rst_cnt[0] - rb, 1);

    // UNDO with empty history
    b = wr_cnt[0]; bb = busy_cnt[0];
    send(2'd1, 4'd0, 1'b0, 1'b0, t);
    wait_idle(20);
    chk("undo_empty_nwrites", wr_cnt[0] - b, 0);
    chk("undo_empty_busy_cycles", busy_cnt[0] - bb, 1);
    chk("undo_empty_solved", sv[0], 1);

    // asynchronous reset in the middle of a GAP
    send(2'd0, 4'd2, 1'b0, 1'b1, t);
    @(posedge sysclk);
    @(posedge sysclk); #2;
    chk("pre_reset_busy", bz[0], 1);
    chk("pre_reset_hist_count", hc0, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_ram_write", rw[0], 0);
    chk("async_rst_ram_reset", rr[0], 0);
    chk("async_rst_busy", bz[0], 0);
    chk("async_rst_cmd_ready", cr[0], 1);
    chk("async_rst_solved", sv[0], 1);
    chk("async_rst_hist_count", hc0, 0);
    @(negedge sysclk); reset = 1'b0;
    repeat (2) @(posedge sysclk);

    // HIST_DEPTH 4: six MOVEs then SOLVE overflows the history
    sel = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(2'd0, 4'd1, 1'b1, 1'b1, t);
      wait_idle(40);
    end
    chk("h4_hist_count_sat", hc1, 4);
    b = wr_cnt[1]; rb = rst_cnt[1];
    send(2'd3, 4'd0, 1'b0, 1'b0, t);
    wait_idle(200);
    chk("h4_solve_nwrites", wr_cnt[1] - b, 4);
    bad = 0;
    for (int i = 0; i < 4; i++) if (wv1[b + i] !== 6'h06) bad++;
    chk("h4_solve_field_errors", bad, 0);
    chk("h4_ram_reset_pulses", rst_cnt[1] - rb, 1);
    chk("h4_hist_count", hc1, 0);
    chk("h4_solved", sv[1], 1);

    chk("no_write_reset_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
